// File: rtl/vga_pkg.sv
// Shared definitions for the VGA test-pattern generator: timing sizes,
// mode encodings, RGB565 colour constants and the per-axis box step helper.
package vga_pkg;

    localparam int H_VALID  = 640;
    localparam int V_VALID  = 480;
    localparam int BOX_SIZE = 64;
    localparam int STEP     = 2;

    typedef enum logic [1:0] {
        MODE_BARS    = 2'd0,
        MODE_CHECKER = 2'd1,
        MODE_BOX     = 2'd2,
        MODE_GRAD    = 2'd3
    } mode_t;

    localparam logic [15:0] RGB_WHITE   = 16'hFFFF;
    localparam logic [15:0] RGB_YELLOW  = 16'hFFE0;
    localparam logic [15:0] RGB_CYAN    = 16'h07FF;
    localparam logic [15:0] RGB_GREEN   = 16'h07E0;
    localparam logic [15:0] RGB_MAGENTA = 16'hF81F;
    localparam logic [15:0] RGB_RED     = 16'hF800;
    localparam logic [15:0] RGB_BLUE    = 16'h001F;
    localparam logic [15:0] RGB_BLACK   = 16'h0000;

    // Position and travel direction of the box along one axis (dir 1 = increasing).
    typedef struct packed {
        logic [9:0] pos;
        logic       dir;
    } axis_t;

    // Pattern cycle order; wraps from GRAD back to BARS.
    function automatic mode_t next_mode(input mode_t cur);
        case (cur)
            MODE_BARS:    next_mode = MODE_CHECKER;
            MODE_CHECKER: next_mode = MODE_BOX;
            MODE_BOX:     next_mode = MODE_GRAD;
            default:      next_mode = MODE_BARS;
        endcase
    endfunction

    // Colour of each of the eight vertical bars, left to right.
    function automatic logic [15:0] bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    bar_colour = RGB_WHITE;
            3'd1:    bar_colour = RGB_YELLOW;
            3'd2:    bar_colour = RGB_CYAN;
            3'd3:    bar_colour = RGB_GREEN;
            3'd4:    bar_colour = RGB_MAGENTA;
            3'd5:    bar_colour = RGB_RED;
            3'd6:    bar_colour = RGB_BLUE;
            default: bar_colour = RGB_BLACK;
        endcase
    endfunction

    // One bounce step along an axis. The sum is taken in 11 bits so that a
    // position near the limit can never wrap back to a small value.
    function automatic axis_t axis_step(input axis_t cur,
                                        input logic [10:0] limit,
                                        input logic [10:0] step);
        logic [10:0] pos11;
        logic [10:0] moved;
        pos11     = {1'b0, cur.pos};
        moved     = 11'd0;
        axis_step = cur;
        if (cur.dir && (pos11 + step >= limit)) begin
            axis_step.pos = limit[9:0];
            axis_step.dir = 1'b0;
        end else if (!cur.dir && (pos11 <= step)) begin
            axis_step.pos = 10'd0;
            axis_step.dir = 1'b1;
        end else begin
            if (cur.dir) begin
                moved = pos11 + step;
            end else begin
                moved = pos11 - step;
            end
            axis_step.pos = moved[9:0];
        end
    endfunction

endpackage

// File: rtl/vga_pic_gen_if.sv
// Pixel request / pixel data bundle between the display timing side
// (master) and the pattern generator (slave).
interface vga_pic_gen_if;
    logic [9:0]  pix_x;
    logic [9:0]  pix_y;
    logic        mode_next;
    logic        freeze;
    logic [15:0] pix_data;
    logic [1:0]  mode;
    logic        frame_tick;

    modport master (
        output pix_x, pix_y, mode_next, freeze,
        input  pix_data, mode, frame_tick
    );

    modport slave (
        input  pix_x, pix_y, mode_next, freeze,
        output pix_data, mode, frame_tick
    );
endinterface

// File: rtl/vga_box_mover.sv
// Bouncing-box position tracker: advances both axes once per frame tick
// unless frozen, reflecting off the screen edges.
module vga_box_mover #(
    parameter int H_VALID  = 640,
    parameter int V_VALID  = 480,
    parameter int BOX_SIZE = 64,
    parameter int STEP     = 2
) (
    input  logic       vga_clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       freeze,
    output logic [9:0] box_x,
    output logic [9:0] box_y
);
    import vga_pkg::*;

    localparam logic [10:0] LIMIT_X = 11'(H_VALID - BOX_SIZE);
    localparam logic [10:0] LIMIT_Y = 11'(V_VALID - BOX_SIZE);
    localparam logic [10:0] STEP11  = 11'(STEP);

    axis_t x_axis;
    axis_t y_axis;
    logic  dir_x;
    logic  dir_y;

    // Box starts in the top-left corner heading down-right; moves once per frame.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            x_axis <= '{pos: 10'd0, dir: 1'b1};
            y_axis <= '{pos: 10'd0, dir: 1'b1};
        end else if (tick && !freeze) begin
            x_axis <= axis_step(x_axis, LIMIT_X, STEP11);
            y_axis <= axis_step(y_axis, LIMIT_Y, STEP11);
        end
    end

    assign box_x = x_axis.pos;
    assign box_y = y_axis.pos;
    assign dir_x = x_axis.dir;
    assign dir_y = y_axis.dir;

endmodule

// File: rtl/vga_pic_gen.sv
// VGA test-pattern generator: produces an RGB565 pixel one cycle after each
// coordinate request, cycling through bars / checker / moving box / gradient
// patterns on request at frame boundaries.
module vga_pic_gen #(
    parameter int H_VALID  = vga_pkg::H_VALID,
    parameter int V_VALID  = vga_pkg::V_VALID,
    parameter int BOX_SIZE = vga_pkg::BOX_SIZE,
    parameter int STEP     = vga_pkg::STEP
) (
    input  logic         vga_clk,
    input  logic         rst,
    vga_pic_gen_if.slave bus
);
    import vga_pkg::*;

    localparam logic [9:0]  H_LIM   = 10'(H_VALID);
    localparam logic [9:0]  V_LIM   = 10'(V_VALID);
    localparam logic [9:0]  X_LAST  = 10'(H_VALID - 1);
    localparam logic [9:0]  Y_LAST  = 10'(V_VALID - 1);
    localparam int          BAR_W   = H_VALID / 8;
    localparam logic [10:0] BOX_W11 = 11'(BOX_SIZE);

    mode_t       mode;
    logic        pend;
    logic        frame_tick;
    logic [15:0] pix_data;
    logic [9:0]  box_x;
    logic [9:0]  box_y;

    logic [15:0] pattern;
    logic [2:0]  bar_idx;
    logic [10:0] x11;
    logic [10:0] y11;
    logic        in_box;
    logic        in_range;

    vga_box_mover #(
        .H_VALID  (H_VALID),
        .V_VALID  (V_VALID),
        .BOX_SIZE (BOX_SIZE),
        .STEP     (STEP)
    ) u_box_mover (
        .vga_clk (vga_clk),
        .rst     (rst),
        .tick    (frame_tick),
        .freeze  (bus.freeze),
        .box_x   (box_x),
        .box_y   (box_y)
    );

    // Frame-end detection and mode sequencing; a request pulse arriving on the
    // advancing tick is kept pending for the following frame.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            mode       <= MODE_BARS;
            pend       <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= (bus.pix_x == X_LAST) && (bus.pix_y == Y_LAST);
            if (frame_tick && pend) begin
                mode <= next_mode(mode);
                pend <= bus.mode_next;
            end else if (bus.mode_next) begin
                pend <= 1'b1;
            end
        end
    end

    // Pattern selection for the currently requested coordinate.
    always_comb begin
        pattern  = RGB_BLACK;
        bar_idx  = 3'd0;
        x11      = {1'b0, bus.pix_x};
        y11      = {1'b0, bus.pix_y};
        in_range = (bus.pix_x < H_LIM) && (bus.pix_y < V_LIM);
        in_box   = (x11 >= {1'b0, box_x}) && (x11 < {1'b0, box_x} + BOX_W11) &&
                   (y11 >= {1'b0, box_y}) && (y11 < {1'b0, box_y} + BOX_W11);
        for (int i = 1; i < 8; i++) begin
            if (bus.pix_x >= 10'(i * BAR_W)) begin
                bar_idx = 3'(i);
            end
        end
        case (mode)
            MODE_BARS:    pattern = bar_colour(bar_idx);
            MODE_CHECKER: pattern = (bus.pix_x[5] ^ bus.pix_y[5]) ? RGB_WHITE : RGB_BLACK;
            MODE_BOX:     pattern = in_box ? RGB_RED : RGB_BLUE;
            default:      pattern = {bus.pix_x[9:5], bus.pix_y[8:3], 5'b00000};
        endcase
    end

    // Output pixel register; blanks anything outside the visible area.
    always_ff @(posedge vga_clk) begin
        if (rst) begin
            pix_data <= RGB_BLACK;
        end else begin
            pix_data <= in_range ? pattern : RGB_BLACK;
        end
    end

    assign bus.pix_data   = pix_data;
    assign bus.mode       = mode;
    assign bus.frame_tick = frame_tick;

endmodule

// File: tb/tb_vga_pic_gen.sv
// Self-checking bench for vga_pic_gen: pixel expectations are queued when a
// coordinate is driven and compared one cycle later; mode, pending request
// and box position follow a small reference model.
module tb_vga_pic_gen;

    logic vga_clk = 1'b0;
    logic rst     = 1'b1;

    vga_pic_gen_if bus();

    vga_pic_gen dut (
        .vga_clk (vga_clk),
        .rst     (rst),
        .bus     (bus.slave)
    );

    always #20 vga_clk = ~vga_clk;

    int checkCount = 0;
    int errorCount = 0;

    string       tagQ[$];
    logic [15:0] expQ[$];

    int modelMode;
    bit modelPend;
    int modelBx, modelBy;
    bit modelDx, modelDy;
    bit modelFreeze;

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [15:0] expectedPixel(input int x, input int y);
        logic [15:0] colours [8];
        colours = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                    16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        if (x >= 640 || y >= 480) return 16'h0000;
        case (modelMode)
            0: return colours[x / 80];
            1: return (((x / 32) + (y / 32)) % 2 == 1) ? 16'hFFFF : 16'h0000;
            2: return (x >= modelBx && x < modelBx + 64 && y >= modelBy && y < modelBy + 64)
                      ? 16'hF800 : 16'h001F;
            default: return 16'((((x / 32) % 32) * 2048) + (((y / 8) % 64) * 32));
        endcase
    endfunction

    function automatic void stepAxis(inout int pos, inout bit dir, input int limit);
        if (dir) begin
            if (pos + 2 >= limit) begin pos = limit; dir = 1'b0; end
            else pos = pos + 2;
        end else begin
            if (pos <= 2) begin pos = 0; dir = 1'b1; end
            else pos = pos - 2;
        end
    endfunction

    function automatic void modelTick(input bit pulseNow);
        if (!modelFreeze) begin
            stepAxis(modelBx, modelDx, 576);
            stepAxis(modelBy, modelDy, 416);
        end
        if (modelPend) begin
            modelMode = (modelMode + 1) % 4;
            modelPend = pulseNow;
        end else if (pulseNow) begin
            modelPend = 1'b1;
        end
    endfunction

    function automatic void modelReset();
        modelMode = 0; modelPend = 0;
        modelBx = 0; modelBy = 0; modelDx = 1; modelDy = 1;
        modelFreeze = 0;
    endfunction

    // Pops the expectation for the coordinate sampled at this edge.
    always @(posedge vga_clk) begin
        #1;
        if (expQ.size() != 0) begin
            checkOutput(tagQ.pop_front(), bus.pix_data, expQ.pop_front());
        end
    end

    task automatic applyStimulus(input logic [9:0] x, input logic [9:0] y, input string tag);
        @(negedge vga_clk);
        bus.pix_x = x;
        bus.pix_y = y;
        tagQ.push_back(tag);
        expQ.push_back(expectedPixel(int'(x), int'(y)));
    endtask

    task automatic pulseModeNext();
        @(negedge vga_clk);
        bus.mode_next = 1'b1;
        @(negedge vga_clk);
        bus.mode_next = 1'b0;
        modelPend = 1'b1;
    endtask

    task automatic runFrameEnd(input bit pulseAtTick);
        applyStimulus(10'd639, 10'd479, "pix_last");
        applyStimulus(10'h3FF, 10'h3FF, "pix_blank");
        checkOutput("frame_tick_hi", bus.frame_tick, 1);
        bus.mode_next = pulseAtTick;
        modelTick(pulseAtTick);
        @(negedge vga_clk);
        bus.mode_next = 1'b0;
        checkOutput("frame_tick_lo", bus.frame_tick, 0);
        checkOutput("mode", bus.mode, modelMode);
        checkOutput("pend", dut.pend, modelPend);
    endtask

    task automatic checkBox(input string tag);
        checkOutput({tag, "_bx"}, dut.box_x, modelBx);
        checkOutput({tag, "_by"}, dut.box_y, modelBy);
        checkOutput({tag, "_dx"}, dut.u_box_mover.dir_x, modelDx);
        checkOutput({tag, "_dy"}, dut.u_box_mover.dir_y, modelDy);
    endtask

    task automatic doReset();
        @(negedge vga_clk);
        rst = 1'b1;
        bus.pix_x = 10'h3FF; bus.pix_y = 10'h3FF;
        bus.mode_next = 1'b0; bus.freeze = 1'b0;
        repeat (2) @(negedge vga_clk);
        modelReset();
        checkOutput("rst_pix", bus.pix_data, 0);
        checkOutput("rst_mode", bus.mode, 0);
        checkOutput("rst_tick", bus.frame_tick, 0);
        checkOutput("rst_pend", dut.pend, 0);
        checkBox("rst");
        rst = 1'b0;
    endtask

    initial begin
        bus.pix_x = 10'h3FF; bus.pix_y = 10'h3FF;
        bus.mode_next = 1'b0; bus.freeze = 1'b0;
        modelReset();

        // Reset state and the basic bar pattern.
        doReset();
        applyStimulus(10'd0,   10'd0,   "bars_0");
        applyStimulus(10'd80,  10'd0,   "bars_80");
        applyStimulus(10'd639, 10'd0,   "bars_639");
        applyStimulus(10'h3FF, 10'h3FF, "blank");
        applyStimulus(10'd400, 10'd10,  "bars_400");
        applyStimulus(10'd100, 10'd480, "y_out");
        applyStimulus(10'd640, 10'd5,   "x_out");

        // Single request advances to CHECKER at frame end.
        pulseModeNext();
        runFrameEnd(1'b0);
        checkOutput("mode_checker", bus.mode, 1);
        applyStimulus(10'd32, 10'd0,  "chk_32_0");
        applyStimulus(10'd32, 10'd32, "chk_32_32");
        applyStimulus(10'd0,  10'd40, "chk_0_40");

        // Three requests in one frame give a single advance.
        pulseModeNext();
        pulseModeNext();
        pulseModeNext();
        runFrameEnd(1'b0);
        checkOutput("mode_box", bus.mode, 2);
        applyStimulus(10'd4,  10'd4,  "box_in");
        applyStimulus(10'd3,  10'd4,  "box_left");
        applyStimulus(10'd67, 10'd4,  "box_right_in");
        applyStimulus(10'd68, 10'd4,  "box_right_out");
        applyStimulus(10'd4,  10'd68, "box_bottom_out");

        // Request coincident with an advancing tick, then with a non-advancing one.
        pulseModeNext();
        runFrameEnd(1'b1);
        checkOutput("mode_grad", bus.mode, 3);
        applyStimulus(10'd100, 10'd200, "grad");
        runFrameEnd(1'b0);
        checkOutput("mode_wrap", bus.mode, 0);
        runFrameEnd(1'b1);
        checkOutput("mode_hold", bus.mode, 0);
        runFrameEnd(1'b0);
        checkOutput("mode_late", bus.mode, 1);

        // Box bounce timing counted from reset.
        doReset();
        pulseModeNext();
        runFrameEnd(1'b0);
        pulseModeNext();
        runFrameEnd(1'b0);
        for (int t = 3; t <= 289; t++) begin
            runFrameEnd(1'b0);
            if (t == 100) begin
                applyStimulus(10'd200, 10'd200, "box100_in");
                applyStimulus(10'd199, 10'd200, "box100_out");
                applyStimulus(10'd263, 10'd263, "box100_corner");
                applyStimulus(10'd264, 10'd200, "box100_edge");
            end
            if (t == 208) begin
                checkOutput("t208_by", dut.box_y, 416);
                checkOutput("t208_dy", dut.u_box_mover.dir_y, 0);
            end
            if (t == 288) begin
                checkOutput("t288_bx", dut.box_x, 576);
                checkOutput("t288_dx", dut.u_box_mover.dir_x, 0);
            end
            if (t == 289) begin
                checkOutput("t289_bx", dut.box_x, 574);
                checkBox("t289");
            end
        end

        // Freeze holds the box while mode requests still work.
        @(negedge vga_clk);
        bus.freeze = 1'b1;
        modelFreeze = 1'b1;
        pulseModeNext();
        for (int t = 0; t < 5; t++) runFrameEnd(1'b0);
        checkOutput("frz_bx", dut.box_x, 574);
        checkBox("frz");
        checkOutput("frz_mode", bus.mode, 3);
        @(negedge vga_clk);
        bus.freeze = 1'b0;
        modelFreeze = 1'b0;
        runFrameEnd(1'b0);
        checkBox("unfrz");

        // Mid-frame reset in GRAD mode with the box at (100,100).
        doReset();
        for (int t = 1; t <= 50; t++) begin
            if (t <= 3) pulseModeNext();
            runFrameEnd(1'b0);
        end
        checkOutput("pre_mode", bus.mode, 3);
        checkOutput("pre_bx", dut.box_x, 100);
        checkOutput("pre_by", dut.box_y, 100);
        applyStimulus(10'd320, 10'd240, "pre_grad");
        @(negedge vga_clk);
        rst = 1'b1;
        bus.pix_x = 10'd639; bus.pix_y = 10'd479;
        bus.mode_next = 1'b1;
        @(negedge vga_clk);
        rst = 1'b0;
        bus.mode_next = 1'b0;
        bus.pix_x = 10'h3FF; bus.pix_y = 10'h3FF;
        modelReset();
        checkOutput("mid_mode", bus.mode, 0);
        checkOutput("mid_pix", bus.pix_data, 0);
        checkOutput("mid_tick", bus.frame_tick, 0);
        checkBox("mid");
        applyStimulus(10'd0,   10'd0,   "post_0");
        checkOutput("post_tick0", bus.frame_tick, 0);
        applyStimulus(10'd480, 10'd5,   "post_480");
        checkOutput("post_tick1", bus.frame_tick, 0);
        applyStimulus(10'd560, 10'd100, "post_560");
        checkOutput("post_tick2", bus.frame_tick, 0);
        runFrameEnd(1'b0);

        repeat (3) @(negedge vga_clk);
        checkOutput("queue_empty", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
